// File: rtl/dac_tx_pkg.sv
// dac_tx_pkg: shared playback state encoding, sample type and midscale code
package dac_tx_pkg;
  localparam int SAMPLE_W = 12;
  typedef logic [SAMPLE_W-1:0] sample_t;
  localparam sample_t MIDSCALE = 12'h800;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, UNDERRUN} state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: single-clock sample buffer with flush and occupancy (clk, rst_n, flush, push/push_data, pop/pop_data, level, ready)
module sample_fifo #(
  parameter int W = 12,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ready
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign ready = level < (AW+1)'(DEPTH);
  assign wr = push && ready && !flush;
  assign rd = pop && level != '0 && !flush;
  assign pop_data = mem[rptr];
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= push_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      wptr <= wptr + AW'(wr);
      rptr <= rptr + AW'(rd);
      level <= level + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/dac_parallel_tx.sv
// dac_parallel_tx: buffered parallel DAC player (CLOCK_50, RESET_N, enable, s_data/s_valid/s_ready in; DAC_DATA, DAC_CLK, level, underrun/clr_underrun)
module dac_parallel_tx
  import dac_tx_pkg::*;
#(
  parameter int DAC_MSB = 11,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV = 4,
  parameter int PRIME_LEVEL = 8,
  parameter int SIGNED_IN = 1
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET_N,
  input  logic                          enable,
  input  logic [DAC_MSB:0]              s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DAC_MSB:0]              DAC_DATA,
  output logic                          DAC_CLK,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          underrun,
  input  logic                          clr_underrun
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DAC_MSB:0] MID = (DAC_MSB+1)'(1) << DAC_MSB;
  state_t state;
  logic [DW-1:0] div, div_n;
  logic tick, pop, flush, starve;
  logic [DAC_MSB:0] head, code;
  assign flush = state != IDLE && !enable;
  assign tick = state != IDLE && div == DW'(CLK_DIV-1);
  assign div_n = (state == IDLE || flush || tick) ? '0 : div + 1'b1;
  assign pop = tick && enable && (state == PRIME ? level >= LW'(PRIME_LEVEL) : state == RUN && level != '0);
  assign starve = tick && enable && state == RUN && level == '0;
  assign code = (SIGNED_IN != 0) ? {~head[DAC_MSB], head[DAC_MSB-1:0]} : head;
  sample_fifo #(.W(DAC_MSB+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLOCK_50),
    .rst_n(RESET_N),
    .flush(flush),
    .push(s_valid),
    .push_data(s_data),
    .pop(pop),
    .pop_data(head),
    .level(level),
    .ready(s_ready)
  );
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      div <= '0;
      DAC_CLK <= 1'b0;
      DAC_DATA <= MID;
      underrun <= 1'b0;
    end else begin
      div <= div_n;
      DAC_CLK <= div_n >= DW'(CLK_DIV/2);
      underrun <= starve || (underrun && !clr_underrun);
      if (flush) begin
        state <= IDLE;
        DAC_DATA <= MID;
      end else
        case (state)
          IDLE: begin
            DAC_DATA <= MID;
            if (enable) state <= PRIME;
          end
          PRIME: if (pop) begin
            DAC_DATA <= code;
            state <= RUN;
          end
          RUN: if (tick) begin
            DAC_DATA <= pop ? code : MID;
            state <= pop ? RUN : UNDERRUN;
          end
          UNDERRUN: state <= PRIME;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_dac_parallel_tx.sv
// tb_dac_parallel_tx: randomized and directed self-check of dac_parallel_tx against a queue-based playback model
module tb_dac_parallel_tx;
  import dac_tx_pkg::*;
  localparam int CD = 4;
  localparam int PL = 8;
  localparam int D = 16;
  logic clk = 0;
  logic RESET_N;
  logic enable, s_valid, s_ready, DAC_CLK, underrun, clr;
  sample_t s_data, DAC_DATA;
  logic [4:0] level;
  int checks = 0;
  int errors = 0;
  sample_t q[$];
  bit m_act, m_play, m_ur;
  int m_t;
  sample_t m_dac;
  dac_parallel_tx dut (
    .CLOCK_50(clk),
    .RESET_N(RESET_N),
    .enable(enable),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .DAC_DATA(DAC_DATA),
    .DAC_CLK(DAC_CLK),
    .level(level),
    .underrun(underrun),
    .clr_underrun(clr)
  );
  always #5 clk = ~clk;
  function automatic sample_t conv(sample_t x);
    return x + 12'd2048;
  endfunction
  task automatic model_reset();
    q.delete();
    m_act = 0;
    m_play = 0;
    m_ur = 0;
    m_t = 0;
    m_dac = MIDSCALE;
  endtask
  always @(posedge clk) begin : model
    int sz;
    bit drop, set;
    if (RESET_N) begin
      sz = q.size();
      drop = m_act && !enable;
      set = 0;
      if (!m_act) begin
        if (enable) begin
          m_act = 1;
          m_t = 0;
        end
      end else if (!enable) begin
        m_act = 0;
        m_play = 0;
        m_t = 0;
        q.delete();
        m_dac = MIDSCALE;
      end else begin
        if (m_t % CD == CD - 1) begin
          if (!m_play) begin
            if (sz >= PL) begin
              m_dac = conv(q.pop_front());
              m_play = 1;
            end
          end else if (sz > 0) m_dac = conv(q.pop_front());
          else begin
            m_dac = MIDSCALE;
            m_ur = 1;
            set = 1;
            m_play = 0;
          end
        end
        m_t++;
      end
      if (!drop && s_valid && sz < D) q.push_back(s_data);
      if (clr && !set) m_ur = 0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic v, input sample_t d, input logic en, input logic c);
    s_valid = v;
    s_data = d;
    enable = en;
    clr = c;
    @(posedge clk);
    #1;
    chk("dac_data", DAC_DATA, m_dac);
    chk("dac_clk", DAC_CLK, m_act && (m_t % CD >= CD / 2));
    chk("level", level, q.size());
    chk("s_ready", s_ready, q.size() < D);
    chk("underrun", underrun, m_ur);
  endtask
  task automatic play_seq(input int n, input int base, input int bound);
    int idx;
    logic prev;
    idx = 0;
    prev = DAC_CLK;
    for (int i = 0; i < bound && idx < n; i++) begin
      cyc(0, 0, 1, 0);
      if (prev && !DAC_CLK) begin
        chk("seq", DAC_DATA, base + idx);
        idx++;
      end
      prev = DAC_CLK;
    end
    chk("seq_count", idx, n);
  endtask
  task automatic stop();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
  endtask
  initial begin
    bit en_r;
    RESET_N = 0;
    enable = 0;
    s_valid = 0;
    s_data = 0;
    clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dac", DAC_DATA, 12'h800);
    chk("rst_clk", DAC_CLK, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_ur", underrun, 0);
    RESET_N = 1;
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, sample_t'(i), 0, 0);
    play_seq(8, 'h800, 60);
    for (int i = 0; i < 20 && !m_ur; i++) cyc(0, 0, 1, 0);
    chk("starve_ur", underrun, 1);
    chk("starve_mid", DAC_DATA, 12'h800);
    stop();
    for (int i = 0; i < 20; i++) cyc(1, sample_t'('h100 + i), 0, 0);
    chk("full_level", level, 16);
    chk("full_ready", s_ready, 0);
    play_seq(16, 'h900, 120);
    stop();
    for (int i = 0; i < 8; i++) cyc(1, sample_t'($urandom), 0, 0);
    for (int i = 0; i < 200 && !(m_play && q.size() == 0); i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < 10 && !m_ur; i++) cyc(0, 0, 1, m_t % CD == CD - 1);
    chk("ur_priority", underrun, 1);
    cyc(0, 0, 1, 1);
    chk("ur_clear", underrun, 0);
    stop();
    for (int i = 0; i < 12; i++) cyc(1, sample_t'($urandom), 0, 0);
    for (int i = 0; i < 200 && !(m_play && q.size() == 5); i++) cyc(0, 0, 1, 0);
    chk("pre_dis_level", level, 5);
    cyc(0, 0, 0, 0);
    chk("dis_level", level, 0);
    chk("dis_dac", DAC_DATA, 12'h800);
    chk("dis_clk", DAC_CLK, 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, sample_t'('h0a0 + i), 0, 0);
    for (int i = 0; i < 50; i++) cyc(0, 0, 1, 0);
    RESET_N = 0;
    model_reset();
    #1;
    chk("arst_dac", DAC_DATA, 12'h800);
    chk("arst_clk", DAC_CLK, 0);
    chk("arst_level", level, 0);
    chk("arst_ready", s_ready, 1);
    chk("arst_ur", underrun, 0);
    #2;
    RESET_N = 1;
    for (int i = 0; i < 8; i++) cyc(1, sample_t'('h300 + i), 0, 0);
    play_seq(8, 'hb00, 60);
    stop();
    en_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) en_r = !en_r;
      cyc($urandom_range(0, 9) < 6, sample_t'($urandom), en_r, $urandom_range(0, 39) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
